// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP16 adder datapath.
// Operand unpacking and the aligner stage-1 bundle live here.
package fp16_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_SIG_W  = 11;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'd31;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_SIG_W-1:0] sig;
    } fp16_op_t;

    typedef struct packed {
        logic [FP16_SIG_W-1:0] big_sig;
        logic [FP16_SIG_W-1:0] small_sig;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_EXP_W-1:0] shamt;
        logic                  sign;
        logic                  if_sub;
        logic                  special;
    } fp16_s1_t;

    // Denormals are flushed: a zero exponent yields a zero significand.
    function automatic fp16_op_t fp16_unpack(
        input logic [15:0] v,
        input logic        flip
    );
        fp16_op_t u;
        u.sign = v[15] ^ flip;
        u.exp  = v[FP16_FRAC_W +: FP16_EXP_W];
        if (u.exp == '0)
            u.sig = '0;
        else
            u.sig = {1'b1, v[FP16_FRAC_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp16_add_aligner_if.sv
// Valid/ready bundle between the operand source, the aligner
// and the significand adder.
interface fp16_add_aligner_if;
    import fp16_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           op_a;
    logic [15:0]           op_b;
    logic                  op_sub;

    logic                  out_valid;
    logic                  out_ready;
    logic                  sign;
    logic                  if_sub;
    logic [FP16_EXP_W-1:0] exponent;
    logic [FP16_SIG_W-1:0] mant_big;
    logic [FP16_SIG_W-1:0] mant_small;
    logic                  special;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, sign, if_sub,
        input  exponent, mant_big, mant_small, special
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, sign, if_sub,
        output exponent, mant_big, mant_small, special
    );

endinterface

// File: rtl/cla_nbit.sv
// Parameterised carry-lookahead adder; every carry is formed
// directly from generate/propagate terms.
module cla_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n-1:0] g;
    logic [n-1:0] p;
    logic [n:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        logic pall;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < n; i++) begin
            pall = cin;
            for (int k = 0; k <= i; k++)
                pall = pall & p[k];
            c[i+1] = pall;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++)
                    term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum  = p ^ c[n-1:0];
    assign cout = c[n];

endmodule

// File: rtl/fp16_add_aligner.sv
// Two-stage FP16 pre-addition aligner: order operands by magnitude,
// then shift the smaller significand to the common exponent.
module fp16_add_aligner
    import fp16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fp16_add_aligner_if.slave  bus
);

    fp16_op_t              ua;
    fp16_op_t              ub;
    logic [FP16_EXP_W-1:0] diff;
    logic                  no_borrow;
    logic                  exp_eq;
    logic                  a_big;
    fp16_s1_t              s1_next;
    fp16_s1_t              s1;
    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_load;
    logic                  s2_load;
    logic                  rdy;
    logic                  take;

    logic [FP16_SIG_W-1:0] al_small;
    logic                  al_sign;

    logic                  r_sign;
    logic                  r_if_sub;
    logic [FP16_EXP_W-1:0] r_exp;
    logic [FP16_SIG_W-1:0] r_big;
    logic [FP16_SIG_W-1:0] r_small;
    logic                  r_special;

    assign ua = fp16_unpack(bus.op_a, 1'b0);
    assign ub = fp16_unpack(bus.op_b, bus.op_sub);

    // exp_a - exp_b; carry-out high means no borrow (exp_a >= exp_b).
    cla_nbit #(.n(FP16_EXP_W)) u_ediff (
        .a    (ua.exp),
        .b    (~ub.exp),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign exp_eq = (diff == '0);
    assign a_big  = (no_borrow && !exp_eq) ||
                    (exp_eq && (ua.sig >= ub.sig));

    always_comb begin
        s1_next         = '0;
        s1_next.if_sub  = ua.sign ^ ub.sign;
        s1_next.special = (ua.exp == FP16_EXP_MAX) ||
                          (ub.exp == FP16_EXP_MAX);
        if (no_borrow)
            s1_next.shamt = diff;
        else
            s1_next.shamt = ~diff + 5'd1;
        if (a_big) begin
            s1_next.big_sig   = ua.sig;
            s1_next.small_sig = ub.sig;
            s1_next.exp       = ua.exp;
            s1_next.sign      = ua.sign;
        end else begin
            s1_next.big_sig   = ub.sig;
            s1_next.small_sig = ua.sig;
            s1_next.exp       = ub.exp;
            s1_next.sign      = ub.sign;
        end
    end

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign bus.in_ready = rdy && s1_load;
    assign take = bus.in_valid && rdy && s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy <= 1'b0;
        else
            rdy <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= take;
            if (take)
                s1 <= s1_next;
        end
    end

    // Equal magnitudes under subtraction give +0; when both operands
    // are zero this also reduces to sign_a & sign_b_eff.
    always_comb begin
        al_small = '0;
        al_sign  = s1.sign;
        if (s1.shamt < 5'(FP16_SIG_W))
            al_small = s1.small_sig >> s1.shamt;
        if (s1.if_sub && (s1.shamt == '0) &&
            (s1.big_sig == s1.small_sig))
            al_sign = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            r_sign    <= 1'b0;
            r_if_sub  <= 1'b0;
            r_exp     <= '0;
            r_big     <= '0;
            r_small   <= '0;
            r_special <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_special <= s1.special;
                if (s1.special) begin
                    r_sign   <= 1'b0;
                    r_if_sub <= 1'b0;
                    r_exp    <= '0;
                    r_big    <= '0;
                    r_small  <= '0;
                end else begin
                    r_sign   <= al_sign;
                    r_if_sub <= s1.if_sub;
                    r_exp    <= s1.exp;
                    r_big    <= s1.big_sig;
                    r_small  <= al_small;
                end
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.sign       = r_sign;
    assign bus.if_sub     = r_if_sub;
    assign bus.exponent   = r_exp;
    assign bus.mant_big   = r_big;
    assign bus.mant_small = r_small;
    assign bus.special    = r_special;

endmodule

// File: tb/tb_fp16_add_aligner.sv
// Scoreboard bench for fp16_add_aligner: directed cases, backpressure,
// mid-stream reset and randomized traffic against a magnitude model.
module tb_fp16_add_aligner;
    import fp16_pkg::*;

    typedef struct {
        logic        sign;
        logic        if_sub;
        logic [4:0]  exp;
        logic [10:0] mb;
        logic [10:0] ms;
        logic        special;
        bit          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   acc_cnt = 0;
    int   mode = 0;
    exp_t sb[$];

    logic        hold = 1'b0;
    logic [29:0] snap = '0;

    fp16_add_aligner_if bus ();

    fp16_add_aligner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
    endtask

    function automatic logic [29:0] outs();
        return {bus.sign, bus.if_sub, bus.exponent,
                bus.mant_big, bus.mant_small, bus.special};
    endfunction

    function automatic logic [29:0] pack(input exp_t e);
        return {e.sign, e.if_sub, e.exp, e.mb, e.ms, e.special};
    endfunction

    // Reference: compare magnitudes as exp*2048+sig, align by division.
    function automatic exp_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic sub);
        exp_t r;
        int ea, eb, ga, gb, ma, mbv, eb_big, es, gbig, gsml;
        bit sa, sbe, sbig;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ga = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        gb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        sa = a[15];
        sbe = b[15] ^ sub;
        r.sign = 0; r.if_sub = 0; r.exp = 0;
        r.mb = 0; r.ms = 0; r.special = 0;
        r.lat = 0; r.acc = 0;
        if (ea == 31 || eb == 31) begin
            r.special = 1;
            return r;
        end
        ma = ea * 2048 + ga;
        mbv = eb * 2048 + gb;
        if (ma >= mbv) begin
            eb_big = ea; es = eb; gbig = ga; gsml = gb; sbig = sa;
        end else begin
            eb_big = eb; es = ea; gbig = gb; gsml = ga; sbig = sbe;
        end
        r.if_sub = sa ^ sbe;
        r.exp = 5'(eb_big);
        r.mb = 11'(gbig);
        r.ms = 11'(gsml / (1 << (eb_big - es)));
        if (ma == 0 && mbv == 0)
            r.sign = sa & sbe;
        else if (r.if_sub && ma == mbv)
            r.sign = 0;
        else
            r.sign = sbig;
        return r;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input bit lat);
        exp_t e;
        bit done;
        done = 0;
        bus.op_a = a;
        bus.op_b = b;
        bus.op_sub = sub;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                e = model(a, b, sub);
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
                acc_cnt++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done)
            chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && sb.size() != 0; t++)
            @(posedge clk);
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v[14:10] = 5'd0;
            1: v[14:10] = 5'd31;
            default: ;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold && bus.out_valid)
                chk("stable", 32'(outs()), 32'(snap));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(outs()), 32'(pack(e)));
                    if (e.lat)
                        chk("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
            hold <= bus.out_valid && !bus.out_ready;
            snap <= outs();
        end
    end

    initial begin
        int base;
        logic [15:0] a, b;
        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.op_sub = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_outputs", 32'(outs()), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_pre_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_post_rst", 32'(bus.in_ready), 32'd1);

        send(16'h3C00, 16'h3C00, 1'b0, 1);
        send(16'h3C00, 16'h3800, 1'b1, 1);
        send(16'h3800, 16'h3C00, 1'b1, 1);
        send(16'h3C00, 16'h3C00, 1'b1, 1);
        send(16'h3C00, 16'h1000, 1'b0, 1);
        send(16'h0000, 16'h4000, 1'b0, 1);
        send(16'h7C00, 16'h3C00, 1'b0, 1);
        send(16'h8000, 16'h8000, 1'b0, 1);
        send(16'h0000, 16'h0000, 1'b1, 1);
        send(16'h3C00, 16'h1400, 1'b0, 1);
        idle();
        drain(50);

        mode = 1;
        @(posedge clk);
        #2;
        base = acc_cnt;
        fork
            begin
                send(16'h4200, 16'h3A00, 1'b0, 0);
                send(16'hC100, 16'h3E00, 1'b1, 0);
                send(16'h2E55, 16'hAA01, 1'b0, 0);
                send(16'h5123, 16'h5122, 1'b1, 0);
                idle();
            end
            begin
                for (int t = 0; t < 50 && acc_cnt < base + 2; t++)
                    @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", 32'(acc_cnt - base), 32'd2);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                @(posedge clk);
                mode = 0;
            end
        join
        drain(50);
        chk("bp_total", 32'(acc_cnt - base), 32'd4);

        mode = 1;
        @(posedge clk);
        #2;
        send(16'h4400, 16'h4000, 1'b0, 0);
        send(16'hBC00, 16'h3555, 1'b1, 0);
        idle();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_outputs", 32'(outs()), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_0", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #2;
        chk("rel_in_ready_1", 32'(bus.in_ready), 32'd1);
        send(16'h3C00, 16'h3800, 1'b1, 1);
        idle();
        drain(50);

        mode = 2;
        @(posedge clk);
        #2;
        for (int i = 0; i < 300; i++) begin
            a = rnd_op();
            case ($urandom_range(0, 3))
                0: b = a ^ 16'h8000;
                1: begin
                    b = rnd_op();
                    b[14:10] = a[14:10];
                end
                default: b = rnd_op();
            endcase
            send(a, b, 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        idle();
        mode = 0;
        drain(200);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fp16_add_aligner.md
# fp16_add_aligner

Pipelined pre-addition alignment stage for the FP16 adder datapath. Accepts two binary16 operands plus an add/subtract opcode, unpacks them, orders them by magnitude, and right-shifts the smaller significand to the larger exponent. It sits directly upstream of the significand adder, whose sum feeds the post-addition normalizer. It produces the sign, effective-subtract flag, common exponent and two aligned 11-bit significands that the normalizer chain consumes.

## Interface

Parameters: none. Formats are fixed to binary16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  aligner can accept a pair this cycle.
- op_a  in  16  operand A, binary16.
- op_b  in  16  operand B, binary16.
- op_sub  in  1  1 = compute A−B; 0 = compute A+B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream adder accepts the result.
- sign  out  1  sign of the final result.
- if_sub  out  1  effective subtraction.
- exponent  out  5  common (larger) biased exponent.
- mant_big  out  11  significand of the larger-magnitude operand, hidden bit included.
- mant_small  out  11  significand of the smaller-magnitude operand, aligned.
- special  out  1  an operand has exponent 31 (Inf/NaN).

## Operation

Unpack:
- exp==0: operand is zero, significand 0 (denormals flushed).
- Otherwise: significand = {1, frac[9:0]}.
- Effective sign of B: sign_b ^ op_sub.

Stage 1 (order):
- Compute ediff = exp_a − exp_b on 5 bits, with the borrow taken from the cla_nbit carry.
- A is the larger operand if exp_a > exp_b, or if the exponents are equal and sig_a >= sig_b. Otherwise swap.
- Register the following:
  - big/small significands
  - big exponent
  - |ediff| (magnitude of ediff)
  - big sign
  - if_sub = sign_a ^ sign_b_eff
  - special

Stage 2 (align):
- mant_small = sig_small >> |ediff|.
- If |ediff| >= 11, mant_small = 0.
- Shifted-out bits are discarded; there are no guard or sticky bits in this version.
- sign = big sign, except when if_sub=1 and the significands and exponents are equal: then sign = 0 (exact zero result is positive).
- Both operands zero: exponent = 0, mant_big = 0, mant_small = 0, sign = sign_a & sign_b_eff.
- special=1: other outputs are forced to 0. Inf/NaN resolution is done downstream.

## Timing

- Latency: 2 cycles from input acceptance (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput: 1 pair per cycle.
- Handshake is valid/ready on both sides; a transfer happens when valid & ready are both high in the same cycle.
- Stage advance rules:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2_load. in_ready is combinational from out_ready; there is no skid buffer.
- Under out_ready=0: stage-2 outputs hold stable and out_valid stays high until accepted. Once both stages are full, in_ready=0.
- Simultaneous accept and issue in the same cycle: both occur, with no bubble.
- Reset, asserted at any time including mid-transfer:
  - out_valid=0, and all internal valids clear.
  - sign, if_sub, exponent, mant_big, mant_small, special all =0.
  - in_ready=1 one cycle after reset deasserts; it is 0 while rst_n=0.
  - In-flight data is dropped.
- in_valid asserted while in_ready=0: the pair is not consumed. Upstream must hold the pair.

## Structure

- Shared package fp16_pkg:
  - constants FP16_EXP_W=5, FP16_FRAC_W=10, FP16_SIG_W=11, FP16_EXP_MAX=5'd31
  - typedef of the unpacked operand struct {sign, exp, sig}
  - The normalizer-side blocks reuse the same package.
- One sub-module, cla_nbit #(.n(5)): the existing carry-lookahead adder, used for the exponent difference (exp_a + ~exp_b + 1).
- The rest is inline:
  - magnitude compare
  - swap
  - barrel right shift
  - two pipeline register banks with valid bits

## Test plan

- 0x3C00 + 0x3C00 (op_sub=0) -> sign=0, if_sub=0, exponent=15, mant_big=0x400, mant_small=0x400, out_valid exactly 2 cycles after acceptance.
- 0x3C00 − 0x3800 (op_sub=1) -> sign=0, if_sub=1, exponent=15, mant_big=0x400, mant_small=0x200.
- 0x3800 − 0x3C00 -> swapped: sign=1, if_sub=1, exponent=15, mant_big=0x400, mant_small=0x200. Also 0x3C00 − 0x3C00 -> sign=0, mant_big=mant_small=0x400.
- 0x3C00 + 0x1000 (ediff=11) -> mant_small=0, exponent=15. Also 0x0000 + 0x4000 -> exponent=16, mant_big=0x400, mant_small=0. Also 0x7C00 + 0x3C00 -> special=1.
- Backpressure: stream 4 back-to-back pairs with out_ready=0 for 3 cycles. Required: in_ready drops after 2 pairs are held, outputs remain stable, then all 4 results emerge in order with no loss or duplication.
- Drop rst_n while both stages are valid -> out_valid=0 and all outputs 0 immediately (asynchronously). After release, the next pair emerges 2 cycles after acceptance.
